// File: rtl/mcu0_ctl.sv
// mcu0_ctl: multi-cycle request/ready control sequencer for the mcu0 accumulator datapath
module mcu0_ctl #(
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [15:0]     ir,
  input  logic            z,
  input  logic            mem_ready,
  output logic            mr,
  output logic            mw,
  output logic            addr_sel,
  output logic            ir_w,
  output logic            pc_w,
  output logic            pcmux,
  output logic            aw,
  output logic            sww,
  output logic [3:0]      aluop,
  output logic [2:0]      state,
  output logic            retire,
  output logic            halted,
  output logic            err,
  output logic [CNTW-1:0] instret
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5, ERR = 3'd6
  } state_t;
  localparam logic [3:0] OP_LD = 4'h0, OP_ADD = 4'h1, OP_JMP = 4'h2, OP_ST = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4, OP_JEQ = 4'h5, OP_HLT = 4'hf;
  localparam logic [3:0] ALU_ZERO = 4'h0, ALU_ADD = 4'h1, ALU_CMP = 4'he, ALU_APASS = 4'hf;
  localparam int WW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TLAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t cur, nxt;
  logic [WW-1:0] wcnt;
  logic [3:0] op, op_alu;
  logic tmo, unused_ir;
  state_t after_retire;
  assign op = ir[15:12];
  assign unused_ir = ^ir[11:0];
  assign state = cur;
  assign op_alu = op == OP_LD ? ALU_APASS : op == OP_ADD ? ALU_ADD : op == OP_CMP ? ALU_CMP : ALU_ZERO;
  // the ack check happens before this, so a late ack on the last allowed cycle still proceeds
  assign tmo = (TIMEOUT != 0) && (wcnt == TLAST);
  assign after_retire = run ? FETCH : IDLE;
  // Mealy strobes and next-state decode
  always_comb begin
    nxt = cur;
    mr = 1'b0;
    mw = 1'b0;
    addr_sel = 1'b0;
    ir_w = 1'b0;
    pc_w = 1'b0;
    pcmux = 1'b0;
    aw = 1'b0;
    sww = 1'b0;
    aluop = ALU_ZERO;
    retire = 1'b0;
    halted = 1'b0;
    err = 1'b0;
    case (cur)
      IDLE: nxt = run ? FETCH : IDLE;
      FETCH: begin
        mr = 1'b1;
        ir_w = mem_ready;
        pc_w = mem_ready;
        nxt = mem_ready ? DECODE : tmo ? ERR : FETCH;
      end
      DECODE: begin
        case (op)
          OP_LD, OP_ADD, OP_CMP, OP_ST: nxt = EXEC;
          OP_JMP: begin
            pc_w = 1'b1;
            pcmux = 1'b1;
            retire = 1'b1;
            nxt = after_retire;
          end
          OP_JEQ: begin
            pc_w = z;
            pcmux = z;
            retire = 1'b1;
            nxt = after_retire;
          end
          OP_HLT: begin
            retire = 1'b1;
            nxt = HALT;
          end
          default: nxt = ERR;
        endcase
      end
      EXEC: begin
        addr_sel = 1'b1;
        if (op == OP_ST) begin
          mw = 1'b1;
          retire = mem_ready;
          nxt = mem_ready ? after_retire : tmo ? ERR : EXEC;
        end else begin
          mr = 1'b1;
          aluop = op_alu;
          nxt = mem_ready ? WB : tmo ? ERR : EXEC;
        end
      end
      WB: begin
        addr_sel = 1'b1;
        aluop = op_alu;
        aw = op == OP_LD || op == OP_ADD;
        sww = op == OP_CMP;
        retire = 1'b1;
        nxt = after_retire;
      end
      HALT: halted = 1'b1;
      ERR: err = 1'b1;
      default: nxt = ERR;
    endcase
  end
  // state register, request wait counter (cleared on every state change) and retire counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cur <= IDLE;
      wcnt <= '0;
      instret <= '0;
    end else begin
      cur <= nxt;
      wcnt <= nxt != cur ? '0 : ((mr | mw) & ~mem_ready) ? wcnt + 1'b1 : wcnt;
      instret <= instret + CNTW'(retire);
    end
  end
endmodule

// File: tb/tb_mcu0_ctl.sv
// tb_mcu0_ctl: directed-step self-checking bench for mcu0_ctl
module tb_mcu0_ctl;
  logic clock = 1'b0, reset = 1'b1, run = 1'b0, z = 1'b0, mem_ready = 1'b0;
  logic [15:0] ir = 16'h0;
  logic mr, mw, addr_sel, ir_w, pc_w, pcmux, aw, sww, retire, halted, err;
  logic [3:0] aluop;
  logic [2:0] state;
  logic [15:0] instret;
  int checks = 0, errors = 0;
  localparam logic [10:0] MR = 11'h400, MW = 11'h200, AS = 11'h100, IRW = 11'h080, PCW = 11'h040;
  localparam logic [10:0] PCM = 11'h020, AW = 11'h010, SWW = 11'h008, RET = 11'h004, HLT = 11'h002, ERB = 11'h001;

  mcu0_ctl #(.CNTW(16), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .run(run), .ir(ir), .z(z), .mem_ready(mem_ready),
    .mr(mr), .mw(mw), .addr_sel(addr_sel), .ir_w(ir_w), .pc_w(pc_w), .pcmux(pcmux),
    .aw(aw), .sww(sww), .aluop(aluop), .state(state), .retire(retire), .halted(halted),
    .err(err), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic step(input logic r, input logic m, input logic zz, input logic [15:0] i);
    @(posedge clock);
    #1;
    run = r;
    mem_ready = m;
    z = zz;
    ir = i;
    #1;
  endtask

  task automatic ck(input string tag, input logic [2:0] s, input logic [3:0] a, input logic [10:0] m);
    logic [17:0] obs, exp;
    obs = {state, aluop, mr, mw, addr_sel, ir_w, pc_w, pcmux, aw, sww, retire, halted, err};
    exp = {s, a, m};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed state=%0d aluop=%h strobes=%h expected state=%0d aluop=%h strobes=%h",
             tag, obs[17:15], obs[14:11], obs[10:0], exp[17:15], exp[14:11], exp[10:0]);
    end
  endtask

  task automatic cv(input string tag, input logic [15:0] e);
    checks++;
    assert (instret === e) else begin
      errors++;
      $error("FAIL %s observed instret=%0d expected %0d", tag, instret, e);
    end
  endtask

  initial begin
    step(0, 0, 0, 16'h0000); ck("reset", 0, 0, 0); cv("reset_cnt", 0);
    reset = 1'b0;
    step(1, 1, 0, 16'h0010); ck("idle_run", 0, 0, 0);
    step(1, 1, 0, 16'h0010); ck("ld_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'h0010); ck("ld_dec", 2, 0, 0);
    step(1, 1, 0, 16'h0010); ck("ld_exec", 3, 4'hf, MR | AS);
    step(1, 1, 0, 16'h0010); ck("ld_wb", 4, 4'hf, AS | AW | RET);
    step(1, 1, 0, 16'h1012); ck("add_fetch", 1, 0, MR | IRW | PCW); cv("cnt_ld", 1);
    step(1, 1, 0, 16'h1012); ck("add_dec", 2, 0, 0);
    step(1, 1, 0, 16'h1012); ck("add_exec", 3, 4'h1, MR | AS);
    step(1, 1, 0, 16'h1012); ck("add_wb", 4, 4'h1, AS | AW | RET);
    step(1, 1, 0, 16'h3014); ck("st_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'h3014); ck("st_dec", 2, 0, 0);
    step(1, 1, 0, 16'h3014); ck("st_exec", 3, 0, MW | AS | RET);
    step(1, 1, 0, 16'h4030); ck("cmp_fetch", 1, 0, MR | IRW | PCW); cv("cnt_prog", 3);
    step(1, 1, 0, 16'h4030); ck("cmp_dec", 2, 0, 0);
    step(1, 1, 0, 16'h4030); ck("cmp_exec", 3, 4'he, MR | AS);
    step(1, 1, 0, 16'h4030); ck("cmp_wb", 4, 4'he, AS | SWW | RET);
    step(1, 1, 1, 16'h5020); ck("jeq1_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 1, 16'h5020); ck("jeq1_dec", 2, 0, PCW | PCM | RET);
    step(1, 1, 0, 16'h5020); ck("jeq0_fetch", 1, 0, MR | IRW | PCW); cv("cnt_jeq", 5);
    step(1, 1, 0, 16'h5020); ck("jeq0_dec", 2, 0, RET);
    step(1, 1, 0, 16'h2040); ck("jmp_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'h2040); ck("jmp_dec", 2, 0, PCW | PCM | RET);
    step(1, 0, 0, 16'h1012); ck("stall_w1", 1, 0, MR);
    step(1, 0, 0, 16'h1012); ck("stall_w2", 1, 0, MR);
    step(1, 0, 0, 16'h1012); ck("stall_w3", 1, 0, MR);
    step(1, 1, 0, 16'h1012); ck("stall_ack", 1, 0, MR | IRW | PCW); cv("cnt_jmp", 7);
    step(1, 1, 0, 16'h1012); ck("stall_dec", 2, 0, 0);
    step(1, 1, 0, 16'h1012); ck("add2_exec", 3, 4'h1, MR | AS);
    step(0, 1, 0, 16'h1012); ck("add2_wb_norun", 4, 4'h1, AS | AW | RET);
    step(0, 1, 0, 16'h1012); ck("to_idle", 0, 0, 0); cv("cnt_add2", 8);
    step(1, 1, 0, 16'h0010); ck("idle_hold", 0, 0, 0);
    step(1, 1, 0, 16'h0010); ck("ld2_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'h0010); ck("ld2_dec", 2, 0, 0);
    step(1, 0, 0, 16'h0010); ck("ld2_w1", 3, 4'hf, MR | AS);
    step(1, 0, 0, 16'h0010); ck("ld2_w2", 3, 4'hf, MR | AS);
    step(1, 0, 0, 16'h0010); ck("ld2_w3", 3, 4'hf, MR | AS);
    step(1, 1, 0, 16'h0010); ck("ld2_late_ack", 3, 4'hf, MR | AS);
    step(1, 1, 0, 16'h0010); ck("ld2_wb", 4, 4'hf, AS | AW | RET);
    step(1, 1, 0, 16'h3014); ck("st2_fetch", 1, 0, MR | IRW | PCW); cv("cnt_ld2", 9);
    step(1, 1, 0, 16'h3014); ck("st2_dec", 2, 0, 0);
    step(1, 0, 0, 16'h3014); ck("st2_exec", 3, 0, MW | AS);
    reset = 1'b1;
    step(1, 0, 0, 16'h3014); ck("st2_reset", 0, 0, 0); cv("cnt_reset", 0);
    reset = 1'b0;
    step(1, 1, 0, 16'h0010); ck("to_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'h0010); ck("to_dec", 2, 0, 0);
    step(1, 0, 0, 16'h0010); ck("to_w1", 3, 4'hf, MR | AS);
    step(1, 0, 0, 16'h0010); ck("to_w2", 3, 4'hf, MR | AS);
    step(1, 0, 0, 16'h0010); ck("to_w3", 3, 4'hf, MR | AS);
    step(1, 0, 0, 16'h0010); ck("to_w4", 3, 4'hf, MR | AS);
    step(0, 0, 0, 16'h0010); ck("to_err", 6, 0, ERB);
    step(1, 1, 0, 16'h0010); ck("err_sticky", 6, 0, ERB);
    step(0, 1, 0, 16'h0010); ck("err_sticky2", 6, 0, ERB); cv("cnt_err", 0);
    reset = 1'b1;
    step(0, 0, 0, 16'hf000); ck("hlt_reset", 0, 0, 0);
    reset = 1'b0;
    step(1, 1, 0, 16'hf000); ck("hlt_idle", 0, 0, 0);
    step(1, 1, 0, 16'hf000); ck("hlt_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'hf000); ck("hlt_dec", 2, 0, RET);
    step(0, 1, 0, 16'hf000); ck("halt", 5, 0, HLT);
    step(1, 1, 0, 16'h0010); ck("halt_sticky", 5, 0, HLT); cv("cnt_hlt", 1);
    reset = 1'b1;
    step(1, 1, 0, 16'h7000); ck("ill_reset", 0, 0, 0);
    reset = 1'b0;
    step(1, 1, 0, 16'h7000); ck("ill_fetch", 1, 0, MR | IRW | PCW);
    step(1, 1, 0, 16'h7000); ck("ill_dec", 2, 0, 0);
    step(1, 1, 0, 16'h7000); ck("ill_err", 6, 0, ERB); cv("cnt_ill", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
